// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit: mult/div busy for MULT_CYCLES/DIV_CYCLES after the start edge, then commit HI/LO.
// mthi/mtlo write on the accepting edge; ops arriving while busy are dropped, and Result_Out is combinational.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        Clk_In,
  input  logic        Reset_In,
  input  logic [5:0]  Op_In,
  input  logic [5:0]  Func_In,
  input  logic        Start_In,
  input  logic [31:0] SrcA_In,
  input  logic [31:0] SrcB_In,
  output logic        Busy_Out,
  output logic [31:0] Hi_Out,
  output logic [31:0] Lo_Out,
  output logic [31:0] Result_Out
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]    state;
  logic [CW-1:0] cnt;
  logic [31:0]   hi;
  logic [31:0]   lo;
  logic [31:0]   opa;
  logic [31:0]   opb;
  logic          op_div;
  logic          op_signed;

  logic          accept;
  logic [63:0]   prod_s;
  logic [63:0]   prod_u;
  logic [31:0]   mag_a;
  logic [31:0]   mag_b;
  logic [31:0]   mag_q;
  logic [31:0]   mag_r;
  logic [31:0]   quot;
  logic [31:0]   rem;
  logic [31:0]   commit_hi;
  logic [31:0]   commit_lo;
  logic          div_by_zero;

  assign accept   = Start_In && (Op_In == 6'b000000) && (state == ST_IDLE);
  assign Busy_Out = (state == ST_BUSY);
  assign Hi_Out   = hi;
  assign Lo_Out   = lo;

  // Results are formed from the latched operands, so the inputs may change freely while busy.
  always_comb begin
    prod_s = $signed({{32{opa[31]}}, opa}) * $signed({{32{opb[31]}}, opb});
    prod_u = {32'b0, opa} * {32'b0, opb};
  end

  // Signed divide runs on magnitudes; quotient and remainder signs are restored afterwards.
  // 0x80000000 / -1 falls out naturally: magnitude 0x80000000, negated back to itself.
  always_comb begin
    mag_a = (op_signed && opa[31]) ? (32'd0 - opa) : opa;
    mag_b = (op_signed && opb[31]) ? (32'd0 - opb) : opb;
    mag_q = (mag_b == 32'd0) ? 32'd0 : (mag_a / mag_b);
    mag_r = (mag_b == 32'd0) ? 32'd0 : (mag_a % mag_b);
    quot  = (op_signed && (opa[31] ^ opb[31])) ? (32'd0 - mag_q) : mag_q;
    rem   = (op_signed && opa[31]) ? (32'd0 - mag_r) : mag_r;
  end

  always_comb begin
    commit_hi   = 32'd0;
    commit_lo   = 32'd0;
    div_by_zero = 1'b0;
    if (op_div) begin
      commit_hi   = rem;
      commit_lo   = quot;
      div_by_zero = (opb == 32'd0);
    end else if (op_signed) begin
      commit_hi = prod_s[63:32];
      commit_lo = prod_s[31:0];
    end else begin
      commit_hi = prod_u[63:32];
      commit_lo = prod_u[31:0];
    end
  end

  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      hi        <= 32'd0;
      lo        <= 32'd0;
      opa       <= 32'd0;
      opb       <= 32'd0;
      op_div    <= 1'b0;
      op_signed <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (accept) begin
        case (Func_In)
          F_MULT, F_MULTU: begin
            opa       <= SrcA_In;
            opb       <= SrcB_In;
            op_div    <= 1'b0;
            op_signed <= (Func_In == F_MULT);
            cnt       <= MULT_LOAD;
            state     <= ST_BUSY;
          end
          F_DIV, F_DIVU: begin
            opa       <= SrcA_In;
            opb       <= SrcB_In;
            op_div    <= 1'b1;
            op_signed <= (Func_In == F_DIV);
            cnt       <= DIV_LOAD;
            state     <= ST_BUSY;
          end
          F_MTHI:  hi <= SrcA_In;
          F_MTLO:  lo <= SrcA_In;
          default: ;
        endcase
      end
    end else begin
      // A zero cycle count behaves as one busy cycle rather than wrapping the counter.
      if (cnt <= CNT_ONE) begin
        state <= ST_IDLE;
        cnt   <= '0;
        if (!div_by_zero) begin
          hi <= commit_hi;
          lo <= commit_lo;
        end
      end else begin
        cnt <= cnt - CNT_ONE;
      end
    end
  end

  always_comb begin
    Result_Out = 32'd0;
    if (Op_In == 6'b000000) begin
      if (Func_In == F_MFHI)      Result_Out = hi;
      else if (Func_In == F_MFLO) Result_Out = lo;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboarded bench for mult_div_unit: directed corner cases plus random mult/div/mt traffic.
module tb_mult_div_unit;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADD   = 6'b100000;

  logic        Clk_In = 1'b0;
  logic        Reset_In = 1'b0;
  logic [5:0]  Op_In = 6'd0;
  logic [5:0]  Func_In = F_ADD;
  logic        Start_In = 1'b0;
  logic [31:0] SrcA_In = 32'd0;
  logic [31:0] SrcB_In = 32'd0;
  logic        Busy_Out;
  logic [31:0] Hi_Out;
  logic [31:0] Lo_Out;
  logic [31:0] Result_Out;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .Clk_In(Clk_In), .Reset_In(Reset_In), .Op_In(Op_In), .Func_In(Func_In),
    .Start_In(Start_In), .SrcA_In(SrcA_In), .SrcB_In(SrcB_In), .Busy_Out(Busy_Out),
    .Hi_Out(Hi_Out), .Lo_Out(Lo_Out), .Result_Out(Result_Out)
  );

  always #5 Clk_In = ~Clk_In;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  bit          abort_pending = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the operands.
  function automatic void model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] eh, output logic [31:0] el, output int cyc);
    longint      sa, sb, q, r;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    eh = m_hi;
    el = m_lo;
    cyc = 10;
    case (f)
      F_MULT: begin
        p = 64'(sa * sb);
        {eh, el} = p;
        cyc = 5;
      end
      F_MULTU: begin
        p = ua * ub;
        {eh, el} = p;
        cyc = 5;
      end
      F_DIV: if (b != 32'd0) begin
        q = sa / sb;
        r = sa % sb;
        el = q[31:0];
        eh = r[31:0];
      end
      F_DIVU: if (b != 32'd0) begin
        el = 32'(ua / ub);
        eh = 32'(ua % ub);
      end
      default: ;
    endcase
  endfunction

  // Monitor: measures each busy window and scores the HI/LO commit when Busy_Out falls.
  initial begin
    bit   prev_busy = 1'b0;
    int   busy_cnt = 0;
    exp_t e;
    forever begin
      @(negedge Clk_In);
      if (Busy_Out === 1'b1) begin
        busy_cnt++;
      end else if (prev_busy) begin
        if (abort_pending) begin
          abort_pending = 1'b0;
        end else if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_commit: busy window of %0d cycles with nothing issued", busy_cnt);
        end else begin
          e = exp_q.pop_front();
          check("busy_len", 32'(busy_cnt), 32'(e.cyc));
          check("commit_hi", Hi_Out, e.hi);
          check("commit_lo", Lo_Out, e.lo);
          m_hi = e.hi;
          m_lo = e.lo;
        end
        busy_cnt = 0;
      end
      prev_busy = (Busy_Out === 1'b1);
    end
  end

  function automatic bit is_md(input logic [5:0] f);
    return (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
  endfunction

  task automatic idle_inputs();
    Start_In = 1'b0;
    Op_In    = 6'd0;
    Func_In  = F_ADD;
  endtask

  // Issue one op with Start_In for a single edge; only call while idle.
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [31:0] eh, el;
    int          cyc;
    Op_In    = 6'd0;
    Func_In  = f;
    SrcA_In  = a;
    SrcB_In  = b;
    Start_In = 1'b1;
    if (is_md(f)) begin
      model(f, a, b, eh, el, cyc);
      e = '{hi: eh, lo: el, cyc: cyc};
      exp_q.push_back(e);
    end
    @(posedge Clk_In);
    #1;
    if (f == F_MTHI) m_hi = a;
    if (f == F_MTLO) m_lo = a;
    idle_inputs();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (Busy_Out && n < 200) begin
      @(posedge Clk_In);
      #1;
      n++;
    end
    if (Busy_Out) begin
      n_cmp++;
      n_bad++;
      $display("FAIL busy_timeout: Busy_Out still 1 after %0d cycles, expected 0", n);
    end
    @(negedge Clk_In);
    #1;
  endtask

  task automatic read_back(input string tag);
    Op_In   = 6'd0;
    Func_In = F_MFHI;
    #1;
    check({tag, "_mfhi"}, Result_Out, m_hi);
    Func_In = F_MFLO;
    #1;
    check({tag, "_mflo"}, Result_Out, m_lo);
    idle_inputs();
  endtask

  task automatic do_reset();
    Reset_In = 1'b1;
    @(posedge Clk_In);
    #1;
    Reset_In = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0]  f;
    logic [31:0] a, b;
    int          k;

    idle_inputs();
    repeat (2) @(posedge Clk_In);
    #1;
    do_reset();
    check("rst_busy", 32'(Busy_Out), 32'd0);
    check("rst_hi", Hi_Out, 32'd0);
    check("rst_lo", Lo_Out, 32'd0);
    read_back("rst");
    repeat (3) @(posedge Clk_In);
    #1;
    check("rst_hold_hi", Hi_Out, 32'd0);

    issue(F_MULT, 32'hFFFFFFFF, 32'h00000002);
    check("mult_busy_early", 32'(Busy_Out), 32'd1);
    wait_idle();
    check("mult_hi", Hi_Out, 32'hFFFFFFFF);
    check("mult_lo", Lo_Out, 32'hFFFFFFFE);
    issue(F_MULTU, 32'hFFFFFFFF, 32'h00000002);
    wait_idle();
    check("multu_hi", Hi_Out, 32'h00000001);
    check("multu_lo", Lo_Out, 32'hFFFFFFFE);

    issue(F_DIV, 32'hFFFFFFF9, 32'd2);
    wait_idle();
    check("div_lo", Lo_Out, 32'hFFFFFFFD);
    check("div_hi", Hi_Out, 32'hFFFFFFFF);
    issue(F_DIVU, 32'd7, 32'd2);
    wait_idle();
    check("divu_lo", Lo_Out, 32'd3);
    check("divu_hi", Hi_Out, 32'd1);
    issue(F_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_idle();
    check("div_ovf_lo", Lo_Out, 32'h80000000);
    check("div_ovf_hi", Hi_Out, 32'd0);

    issue(F_MTHI, 32'h11, 32'd0);
    issue(F_MTLO, 32'h22, 32'd0);
    issue(F_DIVU, 32'd5, 32'd0);
    wait_idle();
    check("div0_hi", Hi_Out, 32'h11);
    check("div0_lo", Lo_Out, 32'h22);
    read_back("div0");

    issue(F_MULT, 32'd3, 32'd4);
    @(posedge Clk_In);
    #1;
    Func_In  = F_MTLO;
    SrcA_In  = 32'h55;
    Start_In = 1'b1;
    @(posedge Clk_In);
    #1;
    idle_inputs();
    check("mtlo_ignored_busy", 32'(Busy_Out), 32'd1);
    wait_idle();
    check("mult34_lo", Lo_Out, 32'd12);
    check("mult34_hi", Hi_Out, 32'd0);

    issue(F_DIV, 32'd100, 32'd7);
    repeat (3) begin
      @(posedge Clk_In);
      #1;
    end
    Func_In  = F_MULT;
    Start_In = 1'b1;
    abort_pending = 1'b1;
    do_reset();
    idle_inputs();
    check("abort_busy", 32'(Busy_Out), 32'd0);
    check("abort_hi", Hi_Out, 32'd0);
    check("abort_lo", Lo_Out, 32'd0);
    repeat (15) @(posedge Clk_In);
    #1;
    check("abort_late_busy", 32'(Busy_Out), 32'd0);
    check("abort_late_hi", Hi_Out, 32'd0);
    check("abort_late_lo", Lo_Out, 32'd0);
    abort_pending = 1'b0;

    issue(F_MTHI, 32'hDEADBEEF, 32'd0);
    check("mthi_hi", Hi_Out, 32'hDEADBEEF);
    check("mthi_busy", 32'(Busy_Out), 32'd0);
    read_back("mthi");

    Op_In    = 6'b000001;
    Func_In  = F_MULT;
    Start_In = 1'b1;
    @(posedge Clk_In);
    #1;
    check("nonzero_op_busy", 32'(Busy_Out), 32'd0);
    Op_In   = 6'd0;
    Func_In = F_ADD;
    SrcA_In = 32'h12345678;
    @(posedge Clk_In);
    #1;
    idle_inputs();
    check("other_func_hi", Hi_Out, m_hi);
    check("other_func_lo", Lo_Out, m_lo);
    check("other_func_busy", 32'(Busy_Out), 32'd0);

    for (int i = 0; i < 24; i++) begin
      k = int'($urandom_range(0, 5));
      a = $urandom();
      b = $urandom();
      if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 40)) - 32'd20;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 20)) - 32'd10;
      if ($urandom_range(0, 7) == 0) b = 32'd0;
      case (k)
        0: f = F_MULT;
        1: f = F_MULTU;
        2: f = F_DIV;
        3: f = F_DIVU;
        4: f = F_MTHI;
        default: f = F_MTLO;
      endcase
      issue(f, a, b);
      if (is_md(f)) begin
        wait_idle();
      end else begin
        check("rand_mt_hi", Hi_Out, m_hi);
        check("rand_mt_lo", Lo_Out, m_lo);
      end
      read_back("rand");
    end

    wait_idle();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
